// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit LFSR stage and its PRBS checker:
// default width/taps, checker FSM encoding and the LFSR next-state function.
package lfsr_pkg;

    localparam int         LFSR_W    = 8;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;   // x^8+x^6+x^5+x^4+1

    // Checker FSM encoding (plain constants keep the encoding fixed for legacy tools)
    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    // Left shift with the XOR of the tapped bits fed into bit 0
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s,
                                                    input logic [LFSR_W-1:0] taps);
        return {s[LFSR_W-2:0], ^(s & taps)};
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// Pure combinational LFSR next-state for arbitrary width and tap mask.
// Bit-exact with lfsr_pkg::lfsr_next at the default width.
module lfsr_step #(
    parameter int         W    = 8,
    parameter logic [W-1:0] TAPS = 8'hB8
) (
    input  logic [W-1:0] s_i,
    output logic [W-1:0] s_o
);

    // Shift left, feedback bit is the parity of the tapped bits
    assign s_o = {s_i[W-2:0], ^(s_i & TAPS)};

endmodule

// File: rtl/lfsr_checker.sv
// PRBS checker for the LFSR stream: seeds a predictor from the data (HUNT),
// confirms LOCK_CNT correct predictions (VERIFY), then counts mismatches
// (LOCKED) until UNLOCK_CNT consecutive misses force a re-hunt.
// Optional: define LFSR_CHK_SAMPLE_CNT_EN to add the sample_cnt output
// (valid samples seen while LOCKED) for bit-error-ratio measurement.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int           W          = LFSR_W,
    parameter logic [W-1:0] TAPS       = LFSR_TAPS,
    parameter int           LOCK_CNT   = 4,
    parameter int           UNLOCK_CNT = 3,
    parameter int           CW         = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    input  logic          clr_cnt,
    output logic          locked,
    output logic          err_pulse,
    output logic [CW-1:0] err_cnt,
`ifdef LFSR_CHK_SAMPLE_CNT_EN
    output logic [CW-1:0] sample_cnt,
`endif
    output logic          lock_loss
);

    localparam int MR_W = $clog2(LOCK_CNT + 1);
    localparam int BR_W = $clog2(UNLOCK_CNT + 1);
    // Run value that, with one more event, completes the lock / unlock
    localparam logic [MR_W-1:0] LOCK_LAST   = MR_W'(LOCK_CNT - 1);
    localparam logic [BR_W-1:0] UNLOCK_LAST = BR_W'(UNLOCK_CNT - 1);

    logic [1:0]      state_q, state_d;
    logic [W-1:0]    pred_q, pred_d;
    logic [MR_W-1:0] match_run_q, match_run_d;
    logic [BR_W-1:0] bad_run_q, bad_run_d;
    logic [CW-1:0]   err_cnt_q, err_cnt_d;
    logic            locked_q, err_pulse_q, lock_loss_q;
    logic            err_hit, loss_hit;
    logic [W-1:0]    seed_next, pred_next;

    lfsr_step #(.W(W), .TAPS(TAPS)) u_step_seed (.s_i(in_data), .s_o(seed_next));
    lfsr_step #(.W(W), .TAPS(TAPS)) u_step_pred (.s_i(pred_q),  .s_o(pred_next));

    // FSM next state, predictor advance and run counters
    always_comb begin
        state_d     = state_q;
        pred_d      = pred_q;
        match_run_d = match_run_q;
        bad_run_d   = bad_run_q;
        err_hit     = 1'b0;
        loss_hit    = 1'b0;
        if (in_valid) begin
            case (state_q)
                ST_HUNT: begin
                    // Zero is the LFSR lock-up value and cannot seed a predictor
                    if (in_data != '0) begin
                        pred_d      = seed_next;
                        match_run_d = '0;
                        state_d     = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (in_data == pred_q) begin
                        pred_d      = pred_next;
                        match_run_d = match_run_q + MR_W'(1);
                        if (match_run_q == LOCK_LAST) begin
                            state_d   = ST_LOCKED;
                            bad_run_d = '0;
                        end
                    end else if (in_data != '0) begin
                        pred_d      = seed_next;
                        match_run_d = '0;
                    end else begin
                        match_run_d = '0;
                        state_d     = ST_HUNT;
                    end
                end
                ST_LOCKED: begin
                    // Free-running predictor: corrupted data must not resync it
                    pred_d = pred_next;
                    if (in_data == pred_q) begin
                        bad_run_d = '0;
                    end else begin
                        err_hit   = 1'b1;
                        bad_run_d = bad_run_q + BR_W'(1);
                        if (bad_run_q == UNLOCK_LAST) begin
                            state_d   = ST_HUNT;
                            loss_hit  = 1'b1;
                            bad_run_d = '0;
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    // Error counter: clear takes effect first, a same-cycle error then counts
    always_comb begin
        err_cnt_d = clr_cnt ? '0 : err_cnt_q;
        if (err_hit && (err_cnt_d != '1)) begin
            err_cnt_d = err_cnt_d + CW'(1);
        end
    end

    // State, predictor, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HUNT;
            pred_q      <= '0;
            match_run_q <= '0;
            bad_run_q   <= '0;
            err_cnt_q   <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            lock_loss_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pred_q      <= pred_d;
            match_run_q <= match_run_d;
            bad_run_q   <= bad_run_d;
            err_cnt_q   <= err_cnt_d;
            locked_q    <= (state_d == ST_LOCKED);
            err_pulse_q <= err_hit;
            lock_loss_q <= loss_hit;
        end
    end

`ifdef LFSR_CHK_SAMPLE_CNT_EN
    logic [CW-1:0] sample_cnt_q, sample_cnt_d;

    // Locked-sample counter, same clear-then-count rule as err_cnt
    always_comb begin
        sample_cnt_d = clr_cnt ? '0 : sample_cnt_q;
        if (in_valid && (state_q == ST_LOCKED) && (sample_cnt_d != '1)) begin
            sample_cnt_d = sample_cnt_d + CW'(1);
        end
    end

    // Sample counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt_q <= '0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
        end
    end

    assign sample_cnt = sample_cnt_q;
`endif

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
    assign lock_loss = lock_loss_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: a vector table for the default build
// (lock, single error, loss of lock, gaps, clear collision, mid-run reset)
// plus a short sequence on a second instance with LOCK_CNT=1 and a 2-bit
// error counter for immediate lock and saturation.
module tb_lfsr_checker;

    logic        clk = 1'b0;
    logic        rst, in_valid, clr_cnt;
    logic [7:0]  in_data;
    logic        locked, err_pulse, lock_loss;
    logic [15:0] err_cnt;

    logic        r2, v2, c2;
    logic [7:0]  d2;
    logic        l2, p2, ll2;
    logic [1:0]  e2;

`ifdef LFSR_CHK_SAMPLE_CNT_EN
    logic [15:0] sample_cnt;
    logic [1:0]  s2;
`endif

    always #5 clk = ~clk;

    lfsr_checker dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .clr_cnt(clr_cnt), .locked(locked), .err_pulse(err_pulse),
        .err_cnt(err_cnt),
`ifdef LFSR_CHK_SAMPLE_CNT_EN
        .sample_cnt(sample_cnt),
`endif
        .lock_loss(lock_loss)
    );

    lfsr_checker #(.LOCK_CNT(1), .CW(2)) dut2 (
        .clk(clk), .rst(r2), .in_valid(v2), .in_data(d2),
        .clr_cnt(c2), .locked(l2), .err_pulse(p2),
        .err_cnt(e2),
`ifdef LFSR_CHK_SAMPLE_CNT_EN
        .sample_cnt(s2),
`endif
        .lock_loss(ll2)
    );

    typedef struct {
        logic        rst;
        logic        vld;
        logic [7:0]  data;
        logic        clr;
        logic        locked;
        logic        pulse;
        logic [15:0] cnt;
        logic        loss;
        logic [15:0] scnt;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic vec_t mk(logic r, logic v, logic [7:0] d, logic c,
                                logic l, logic p, logic [15:0] e, logic ll,
                                logic [15:0] s);
        vec_t t;
        t.rst = r; t.vld = v; t.data = d; t.clr = c;
        t.locked = l; t.pulse = p; t.cnt = e; t.loss = ll; t.scnt = s;
        return t;
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s row %0d: got %0h want %0h", nm, row, got, want);
    endtask

    task automatic step2(input logic v, input logic [7:0] d);
        @(negedge clk);
        r2 = 1'b0; v2 = v; d2 = d; c2 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; clr_cnt = 1'b0;
        r2  = 1'b1; v2 = 1'b0; d2 = '0; c2 = 1'b0;

        //               rst v  data  clr  locked pulse cnt loss scnt
        // reset, zeros in HUNT, lock with a gap after the seed
        tbl.push_back(mk(1, 0, 8'h00, 0,   0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, 0,   0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h00, 0,   0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h00, 0,   0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h05, 0,   0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h0A, 0,   0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h0A, 0,   0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h15, 0,   0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h2B, 0,   0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h56, 0,   1, 0, 0, 0, 0));
        // single error (00 for AD), good 5B clears bad_run so two more misses keep lock
        tbl.push_back(mk(0, 1, 8'h00, 0,   1, 1, 1, 0, 1));
        tbl.push_back(mk(0, 1, 8'h5B, 0,   1, 0, 1, 0, 2));
        tbl.push_back(mk(0, 1, 8'h00, 0,   1, 1, 2, 0, 3));
        tbl.push_back(mk(0, 1, 8'h00, 0,   1, 1, 3, 0, 4));
        tbl.push_back(mk(0, 1, 8'hDA, 0,   1, 0, 3, 0, 5));
        tbl.push_back(mk(0, 0, 8'hFF, 0,   1, 0, 3, 0, 5));
        // clear colliding with a counted error, then loss of lock on the third miss
        tbl.push_back(mk(0, 1, 8'hFF, 1,   1, 1, 1, 0, 1));
        tbl.push_back(mk(0, 1, 8'hFF, 0,   1, 1, 2, 0, 2));
        tbl.push_back(mk(0, 1, 8'hFF, 0,   0, 1, 3, 1, 3));
        tbl.push_back(mk(0, 0, 8'h00, 0,   0, 0, 3, 0, 3));
        tbl.push_back(mk(0, 0, 8'h00, 1,   0, 0, 0, 0, 0));
        // re-lock on a clean sequence
        tbl.push_back(mk(0, 1, 8'h05, 0,   0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h0A, 0,   0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h15, 0,   0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h2B, 0,   0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h56, 0,   1, 0, 0, 0, 0));
        // build err_cnt to 5 without losing lock
        tbl.push_back(mk(0, 1, 8'h00, 0,   1, 1, 1, 0, 1));
        tbl.push_back(mk(0, 1, 8'h5B, 0,   1, 0, 1, 0, 2));
        tbl.push_back(mk(0, 1, 8'h00, 0,   1, 1, 2, 0, 3));
        tbl.push_back(mk(0, 1, 8'h00, 0,   1, 1, 3, 0, 4));
        tbl.push_back(mk(0, 1, 8'hDA, 0,   1, 0, 3, 0, 5));
        tbl.push_back(mk(0, 1, 8'h00, 0,   1, 1, 4, 0, 6));
        tbl.push_back(mk(0, 1, 8'h00, 0,   1, 1, 5, 0, 7));
        // mid-run reset while locked
        tbl.push_back(mk(1, 1, 8'hD6, 0,   0, 0, 0, 0, 0));
        // VERIFY zero mismatch returns to HUNT; re-seed from 0A needs four more matches
        tbl.push_back(mk(0, 1, 8'h00, 0,   0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h05, 0,   0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h00, 0,   0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h0A, 0,   0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h15, 0,   0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h2B, 0,   0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h56, 0,   0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hAD, 0,   1, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst = tbl[i].rst; in_valid = tbl[i].vld;
            in_data = tbl[i].data; clr_cnt = tbl[i].clr;
            @(posedge clk);
            #1;
            chk("locked",    i, 32'(locked),    32'(tbl[i].locked));
            chk("err_pulse", i, 32'(err_pulse), 32'(tbl[i].pulse));
            chk("err_cnt",   i, 32'(err_cnt),   32'(tbl[i].cnt));
            chk("lock_loss", i, 32'(lock_loss), 32'(tbl[i].loss));
`ifdef LFSR_CHK_SAMPLE_CNT_EN
            chk("sample_cnt", i, 32'(sample_cnt), 32'(tbl[i].scnt));
`endif
        end

        // LOCK_CNT=1: lock on the first correct prediction; 2-bit counter saturates
        @(negedge clk);
        r2 = 1'b1;
        @(posedge clk);
        #1;
        chk("u2_reset_locked", 100, 32'(l2), 32'(0));
        step2(1'b1, 8'h05);
        chk("u2_seed_locked", 101, 32'(l2), 32'(0));
        step2(1'b1, 8'h0A);
        chk("u2_lock1", 102, 32'(l2), 32'(1));
        step2(1'b1, 8'h00);
        chk("u2_err1", 103, 32'(e2), 32'(1));
        step2(1'b1, 8'h2B);
        step2(1'b1, 8'h00);
        chk("u2_err2", 104, 32'(e2), 32'(2));
        step2(1'b1, 8'hAD);
        step2(1'b1, 8'h00);
        chk("u2_err3", 105, 32'(e2), 32'(3));
        step2(1'b1, 8'hB6);
        step2(1'b1, 8'h00);
        chk("u2_sat_cnt",   106, 32'(e2),  32'(3));
        chk("u2_sat_pulse", 107, 32'(p2),  32'(1));
        chk("u2_sat_lock",  108, 32'(l2),  32'(1));
        chk("u2_no_loss",   109, 32'(ll2), 32'(0));
`ifdef LFSR_CHK_SAMPLE_CNT_EN
        chk("u2_sample_sat", 110, 32'(s2), 32'(3));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
